// File: rtl/pll_supervisor_pkg.sv
// ---------------------------------------------------------------------------
// pll_supervisor_pkg
//   Shared definitions for the PLL reset/lock supervisor:
//     - supervisor state encoding (fixed values, visible in waveforms/debug)
//     - width of the retry counter and of the optional lock-loss counter
//     - a small helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } sup_state_t;

    localparam int RETRY_W  = 4;
    localparam int LOSS_W   = 8;
    localparam int LOSS_MAX = (2 ** LOSS_W) - 1;

    // Largest of three values, used to size the single shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Generic 1-bit two-flop synchroniser for asynchronous inputs.
//   Both stages reset asynchronously to 0, so a synchronised "good" flag
//   always reads as inactive coming out of reset.
// Ports
//   clk   in  1  destination clock
//   rst   in  1  asynchronous, active-high reset
//   d     in  1  asynchronous input
//   q     out 1  synchronised output, 2 cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First stage may go metastable; the second stage gives it a full cycle
    // to resolve before anything downstream looks at the value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_supervisor.sv
// ---------------------------------------------------------------------------
// pll_supervisor
//   Reset/lock supervisor running on the crystal clock. Holds the PLL core in
//   reset, waits for lock, requires the lock to stay up for a while, then
//   releases the system reset and raises ready. A lock timeout retries the
//   PLL; too many retries end in a sticky FAULT that only reset clears.
//   sys_rst and ready must be re-synchronised by their consumers into the
//   PLL output clock domain.
//
// Optional feature macro: PLL_SUP_LOSS_CNT_EN
//   When defined, lock_loss_cnt exists and counts RUN->PLL_RST transitions
//   (saturating at 255, cleared only by reset).
//
// Parameters
//   PLL_RST_CYCLES       cycles pll_reset_n is held low per attempt (>=1)
//   LOCK_TIMEOUT_CYCLES  cycles allowed waiting for lock before a retry (>=2)
//   LOCK_STABLE_CYCLES   consecutive lock cycles needed before release (>=1)
//   MAX_RETRIES          retries allowed before FAULT (1..15)
// Ports
//   clk_in         in   1  crystal clock (also feeds the PLL core)
//   reset          in   1  asynchronous, active-high reset
//   pll_locked     in   1  PLL lock indicator, asynchronous to clk_in
//   pll_reset_n    out  1  PLL core reset, low = PLL held in reset
//   sys_rst        out  1  active-high reset for the PLL-clocked logic
//   ready          out  1  PLL locked, stable and system released
//   fault          out  1  sticky, retries exhausted
//   retry_cnt      out  4  PLL reset attempts since last entry to RUN
//   lock_loss_cnt  out  8  lock losses while running (macro only)
// ---------------------------------------------------------------------------
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               pll_locked,
    output logic               pll_reset_n,
    output logic               sys_rst,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_SUP_LOSS_CNT_EN
    ,
    output logic [LOSS_W-1:0]  lock_loss_cnt
`endif
);

    // One counter serves every timed state, so it only has to cover the
    // longest of the three intervals.
    localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    // Parameter range checks at elaboration time.
    if (PLL_RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("pll_supervisor: PLL_RST_CYCLES must be >= 1");
    end
    if (LOCK_TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("pll_supervisor: LOCK_TIMEOUT_CYCLES must be >= 2");
    end
    if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable
        $error("pll_supervisor: LOCK_STABLE_CYCLES must be >= 1");
    end
    if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_retries
        $error("pll_supervisor: MAX_RETRIES must be in 1..15");
    end

    sup_state_t       state;
    sup_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;

    logic             pll_reset_n_d;
    logic             sys_rst_d;
    logic             ready_d;
    logic             fault_d;

    sync_2ff u_lock_sync (
        .clk (clk_in),
        .rst (reset),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // State register plus the shared interval counter. The counter restarts
    // on every state change, so each timed state measures from its own entry
    // (including STABLE->WAIT_LOCK, which therefore restarts the timeout).
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= PLL_RST;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next-state logic. In WAIT_LOCK a lock seen in the same cycle as the
    // timeout takes priority over the retry/fault decision.
    always_comb begin
        next_state = state;
        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    next_state = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state = (retry_cnt == RETRY_LIMIT) ? FAULT : PLL_RST;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    next_state = PLL_RST;
                end
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = PLL_RST;
            end
        endcase
    end

    // Output decode from the state being entered, so the registered outputs
    // change on the same edge as the state (e.g. ready in the first RUN cycle).
    always_comb begin
        pll_reset_n_d = (next_state != PLL_RST) && (next_state != FAULT);
        sys_rst_d     = (next_state != RUN);
        ready_d       = (next_state == RUN);
        fault_d       = (next_state == FAULT);
    end

    // Registered outputs; reset values hold the PLL and the system in reset.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pll_reset_n <= 1'b0;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            pll_reset_n <= pll_reset_n_d;
            sys_rst     <= sys_rst_d;
            ready       <= ready_d;
            fault       <= fault_d;
        end
    end

    // Retry counter: one count per timeout-triggered PLL reset, cleared once
    // the system reaches RUN. Holds its value in FAULT for diagnosis.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            retry_cnt <= '0;
        end else if ((next_state == RUN) && (state != RUN)) begin
            retry_cnt <= '0;
        end else if ((state == WAIT_LOCK) && (next_state == PLL_RST)) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    // Lock-loss counter: counts every drop out of RUN, saturating so a
    // flapping PLL never wraps back to a small, reassuring number.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            lock_loss_cnt <= '0;
        end else if ((state == RUN) && (next_state == PLL_RST) &&
                     (lock_loss_cnt != LOSS_W'(LOSS_MAX))) begin
            lock_loss_cnt <= lock_loss_cnt + 1'b1;
        end
    end
`else
    // No lock-loss counter in this build.
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_supervisor
//   Self-checking bench for pll_supervisor with short parameters (4/32/8/2).
//   A behavioural reference model tracks the supervisor phase per cycle and
//   every output is compared each cycle; directed scenarios add checks at
//   absolute cycle numbers derived by hand. Works with or without
//   PLL_SUP_LOSS_CNT_EN.
// ---------------------------------------------------------------------------
module tb_pll_supervisor;

    localparam int RST_C = 4;
    localparam int TO_C  = 32;
    localparam int ST_C  = 8;
    localparam int MAXR  = 2;

    localparam int P_RST   = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_RUN   = 3;
    localparam int P_FAULT = 4;

    logic       clk_in     = 1'b0;
    logic       reset      = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_reset_n;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
`ifdef PLL_SUP_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int m_phase   = P_RST;
    int m_elapsed = 0;
    int m_retries = 0;
    int m_losses  = 0;
    bit lk_q[$]   = '{1'b0, 1'b0};

    pll_supervisor #(
        .PLL_RST_CYCLES      (RST_C),
        .LOCK_TIMEOUT_CYCLES (TO_C),
        .LOCK_STABLE_CYCLES  (ST_C),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .pll_reset_n   (pll_reset_n),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt)
`ifdef PLL_SUP_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    // 100 MHz crystal clock.
    initial begin
        forever #5 clk_in = ~clk_in;
    end

    // Cycle number since reset release: edge k after release gives cyc == k.
    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
        end
    end

    // Reference model. The lock seen by the supervisor on an edge is the
    // pll_locked level sampled two edges earlier; phases are timed by the
    // number of cycles spent in them.
    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            m_phase   = P_RST;
            m_elapsed = 0;
            m_retries = 0;
            m_losses  = 0;
            lk_q      = '{1'b0, 1'b0};
        end else begin
            bit seen;
            int nxt;
            seen = lk_q[0];
            void'(lk_q.pop_front());
            lk_q.push_back(pll_locked);
            nxt = m_phase;
            if (m_phase == P_RST) begin
                if (m_elapsed == RST_C - 1) nxt = P_WAIT;
            end else if (m_phase == P_WAIT) begin
                if (seen) begin
                    nxt = P_STAB;
                end else if (m_elapsed == TO_C - 1) begin
                    if (m_retries == MAXR) begin
                        nxt = P_FAULT;
                    end else begin
                        m_retries = m_retries + 1;
                        nxt = P_RST;
                    end
                end
            end else if (m_phase == P_STAB) begin
                if (!seen) begin
                    nxt = P_WAIT;
                end else if (m_elapsed == ST_C - 1) begin
                    nxt = P_RUN;
                    m_retries = 0;
                end
            end else if (m_phase == P_RUN) begin
                if (!seen) begin
                    nxt = P_RST;
                    if (m_losses < 255) m_losses = m_losses + 1;
                end
            end
            m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
            m_phase   = nxt;
        end
    end

    // Single checking task: counts the comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d time %0t",
                     tag, got, exp, cyc, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model, 2 ns after the edge.
    always begin
        @(posedge clk_in);
        #2;
        checkOutput("cyc_pll_reset_n", 32'(pll_reset_n), 32'((m_phase != P_RST) && (m_phase != P_FAULT)));
        checkOutput("cyc_sys_rst",     32'(sys_rst),     32'(m_phase != P_RUN));
        checkOutput("cyc_ready",       32'(ready),       32'(m_phase == P_RUN));
        checkOutput("cyc_fault",       32'(fault),       32'(m_phase == P_FAULT));
        checkOutput("cyc_retry_cnt",   32'(retry_cnt),   32'(m_retries));
`ifdef PLL_SUP_LOSS_CNT_EN
        checkOutput("cyc_lock_loss",   32'(lock_loss_cnt), 32'(m_losses));
`endif
    end

    // Hold pll_locked at lvl for n full clock periods, changing at a falling edge.
    task automatic applyStimulus(input logic lvl, input int n);
        @(negedge clk_in);
        pll_locked = lvl;
        repeat (n - 1) @(negedge clk_in);
    endtask

    // Advance to 2 ns after edge n (i.e. inside cycle n).
    task automatic atCycle(input int n);
        while (cyc < n) begin
            @(posedge clk_in);
            #1;
        end
        #1;
    endtask

    // Change pll_locked at the falling edge inside cycle n.
    task automatic driveAt(input int n, input logic lvl);
        atCycle(n);
        @(negedge clk_in);
        pll_locked = lvl;
    endtask

    // Assert reset mid-cycle, confirm outputs drop to reset values at once,
    // then release at a falling edge (the next rising edge is cycle 1).
    task automatic doReset(input string tag);
        @(negedge clk_in);
        reset = 1'b1;
        #1;
        checkOutput({tag, "_pll_reset_n"}, 32'(pll_reset_n), 32'd0);
        checkOutput({tag, "_sys_rst"},     32'(sys_rst),     32'd1);
        checkOutput({tag, "_ready"},       32'(ready),       32'd0);
        checkOutput({tag, "_fault"},       32'(fault),       32'd0);
        checkOutput({tag, "_retry_cnt"},   32'(retry_cnt),   32'd0);
`ifdef PLL_SUP_LOSS_CNT_EN
        checkOutput({tag, "_lock_loss"},   32'(lock_loss_cnt), 32'd0);
`endif
        pll_locked = 1'b0;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] pll_supervisor bench start");
        repeat (2) @(negedge clk_in);

        // Normal bring-up with lock from cycle 10.
        doReset("rst0");
        atCycle(3);
        checkOutput("up_prn_c3", 32'(pll_reset_n), 32'd0);
        atCycle(4);
        checkOutput("up_prn_c4", 32'(pll_reset_n), 32'd1);
        driveAt(10, 1'b1);
        atCycle(20);
        checkOutput("up_ready_c20", 32'(ready), 32'd0);
        atCycle(21);
        checkOutput("up_ready_c21", 32'(ready), 32'd1);
        checkOutput("up_sysrst_c21", 32'(sys_rst), 32'd0);
        checkOutput("up_retry_c21", 32'(retry_cnt), 32'd0);

        // Lock stuck low: two retries, then FAULT; reset clears it.
        doReset("rst1");
        atCycle(35);
        checkOutput("stuck_retry_c35", 32'(retry_cnt), 32'd0);
        atCycle(36);
        checkOutput("stuck_retry_c36", 32'(retry_cnt), 32'd1);
        checkOutput("stuck_prn_c36", 32'(pll_reset_n), 32'd0);
        atCycle(72);
        checkOutput("stuck_retry_c72", 32'(retry_cnt), 32'd2);
        atCycle(107);
        checkOutput("stuck_fault_c107", 32'(fault), 32'd0);
        atCycle(108);
        checkOutput("stuck_fault_c108", 32'(fault), 32'd1);
        checkOutput("stuck_prn_c108", 32'(pll_reset_n), 32'd0);
        checkOutput("stuck_sysrst_c108", 32'(sys_rst), 32'd1);
        atCycle(150);
        checkOutput("stuck_fault_c150", 32'(fault), 32'd1);
        doReset("rst2");

        // Lock drop of 3 cycles while STABLE (stable count 5 at cycle 18).
        driveAt(10, 1'b1);
        driveAt(16, 1'b0);
        driveAt(19, 1'b1);
        atCycle(21);
        checkOutput("stab_ready_c21", 32'(ready), 32'd0);
        atCycle(29);
        checkOutput("stab_ready_c29", 32'(ready), 32'd0);
        atCycle(30);
        checkOutput("stab_ready_c30", 32'(ready), 32'd1);
        checkOutput("stab_retry_c30", 32'(retry_cnt), 32'd0);

        // One-cycle lock drop in RUN, then relock.
        driveAt(35, 1'b0);
        driveAt(36, 1'b1);
        atCycle(37);
        checkOutput("loss_ready_c37", 32'(ready), 32'd1);
        atCycle(38);
        checkOutput("loss_sysrst_c38", 32'(sys_rst), 32'd1);
        checkOutput("loss_ready_c38", 32'(ready), 32'd0);
        checkOutput("loss_prn_c38", 32'(pll_reset_n), 32'd0);
`ifdef PLL_SUP_LOSS_CNT_EN
        checkOutput("loss_cnt_c38", 32'(lock_loss_cnt), 32'd1);
`endif
        atCycle(50);
        checkOutput("relock_ready_c50", 32'(ready), 32'd0);
        atCycle(51);
        checkOutput("relock_ready_c51", 32'(ready), 32'd1);

        // Reset asserted while STABLE, then while RUN.
        doReset("rst3");
        driveAt(10, 1'b1);
        atCycle(15);
        doReset("rst_stable");
        driveAt(10, 1'b1);
        atCycle(22);
        checkOutput("run_ready_c22", 32'(ready), 32'd1);
        doReset("rst_run");

        // Randomised lock activity, mostly long highs with short drops,
        // occasional long lows to force timeouts and rare resets.
        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = int'($urandom_range(0, 59));
            if (sel == 0) begin
                doReset("rnd_rst");
            end else if (sel < 8) begin
                applyStimulus(1'b0, int'($urandom_range(40, 120)));
            end else if (sel < 30) begin
                applyStimulus(1'b0, int'($urandom_range(1, 6)));
            end else begin
                applyStimulus(1'b1, int'($urandom_range(1, 60)));
            end
        end

`ifdef PLL_SUP_LOSS_CNT_EN
        // 300 lock losses from RUN: the counter must saturate at 255.
        doReset("rst_sat");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 20);
            applyStimulus(1'b0, 1);
        end
        applyStimulus(1'b1, 20);
        checkOutput("loss_saturated", 32'(lock_loss_cnt), 32'd255);
`endif

        repeat (3) @(posedge clk_in);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
